lcd_seq: RTL and testbench

LCD_SEQ -- requirements
Module: lcd_seq

---
 rtl/lcd_seq.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_seq.sv
// ---------------------------------------------------------------------------
// lcd_seq
// Write-only parallel LCD panel sequencer. Runs the panel reset sequence
// (lcd_rst low, then a settling wait), then drains a 4-entry command FIFO
// onto the panel bus. Each write has three phases: setup (bus stable, wr high),
// strobe (wr low) and hold (wr high, bus held).
//
// Ports
//   clk_i        single clock, all state changes on the rising edge
//   rst_i        asynchronous active-high reset
//   cmd_valid_i  command present
//   cmd_ready_o  command accepted when valid and ready are both high
//   cmd_rs_i     RS for the command (0 = command, 1 = data)
//   cmd_data_i   24-bit bus word
//   blk_en_i     backlight request
//   soft_rst_i   level; restarts the panel reset sequence and flushes the FIFO
//   lcd_blk_o, lcd_rs_o, lcd_wr_o, lcd_rd_o, lcd_rst_o  registered panel strobes
//   lcd_data_o   registered panel data bus
//   busy_o       sequencer not idle or FIFO non-empty
//   init_done_o  panel reset sequence complete
// ---------------------------------------------------------------------------
module lcd_seq #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_WRL   = 4,
  parameter int unsigned T_WRH   = 4,
  parameter int unsigned T_RST   = 16,
  parameter int unsigned T_RWAIT = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_rs_i,
  input  logic [23:0] cmd_data_i,
  input  logic        blk_en_i,
  input  logic        soft_rst_i,
  output logic        lcd_blk_o,
  output logic        lcd_rs_o,
  output logic        lcd_wr_o,
  output logic        lcd_rd_o,
  output logic        lcd_rst_o,
  output logic [23:0] lcd_data_o,
  output logic        busy_o,
  output logic        init_done_o
);

  typedef enum logic [2:0] {RST_HOLD, RST_WAIT, IDLE, SETUP, WRL, WRH} state_t;

  // The hold phase compares against T_RST rather than T_RST-1: the edge that
  // (re)starts the sequence only arms the counter, so lcd_rst stays low for
  // T_RST full cycles after reset or soft_rst is released.
  localparam logic [15:0] HOLD_LAST  = 16'(T_RST);
  localparam logic [15:0] WAIT_LAST  = 16'(T_RWAIT - 1);
  localparam logic [15:0] SETUP_LAST = 16'(T_SETUP - 1);
  localparam logic [15:0] WRL_LAST   = 16'(T_WRL - 1);
  localparam logic [15:0] WRH_LAST   = 16'(T_WRH - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        lcd_blk_q, lcd_rs_q, lcd_wr_q, lcd_rst_q, init_done_q;
  logic [23:0] lcd_data_q;

  logic [24:0] mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        fifo_empty, fifo_full, push, pop, phase_done;
  logic [24:0] head;

  // FIFO status and handshake; soft_rst blocks new commands while it is high.
  assign fifo_empty  = (count_q == 3'd0);
  assign fifo_full   = (count_q == 3'd4);
  assign cmd_ready_o = !fifo_full && !soft_rst_i;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign head        = mem_q[rd_ptr_q];

  // Terminal count of the current phase; IDLE has no duration of its own.
  always_comb begin
    phase_done = 1'b0;
    case (state_q)
      RST_HOLD: phase_done = (cnt_q == HOLD_LAST);
      RST_WAIT: phase_done = (cnt_q == WAIT_LAST);
      IDLE:     phase_done = 1'b1;
      SETUP:    phase_done = (cnt_q == SETUP_LAST);
      WRL:      phase_done = (cnt_q == WRL_LAST);
      WRH:      phase_done = (cnt_q == WRH_LAST);
      default:  phase_done = 1'b0;
    endcase
  end

  // A pop happens from IDLE, or at the last hold cycle so back-to-back
  // writes chain straight into the next setup without an idle cycle.
  assign pop = !soft_rst_i && !fifo_empty &&
               ((state_q == IDLE) || ((state_q == WRH) && phase_done));

  assign count_d = count_q + {2'b00, push} - {2'b00, pop};

  // FIFO storage; only written on an accepted command, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_rs_i, cmd_data_i};
    end
  end

  // FIFO pointers and occupancy; soft_rst discards everything queued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else if (soft_rst_i) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

  // Sequencer FSM with the shared phase counter and all registered panel
  // outputs. Strobe levels change on the same edge as the state transition.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RST_HOLD;
      cnt_q       <= 16'd0;
      lcd_blk_q   <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_wr_q    <= 1'b1;
      lcd_rst_q   <= 1'b0;
      lcd_data_q  <= 24'd0;
      init_done_q <= 1'b0;
    end else begin
      lcd_blk_q <= blk_en_i;
      if (soft_rst_i) begin
        state_q     <= RST_HOLD;
        cnt_q       <= 16'd0;
        lcd_wr_q    <= 1'b1;
        lcd_rst_q   <= 1'b0;
        init_done_q <= 1'b0;
      end else begin
        case (state_q)
          RST_HOLD: begin
            if (phase_done) begin
              state_q   <= RST_WAIT;
              cnt_q     <= 16'd0;
              lcd_rst_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          RST_WAIT: begin
            if (phase_done) begin
              state_q     <= IDLE;
              cnt_q       <= 16'd0;
              init_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          IDLE: begin
            if (pop) begin
              state_q    <= SETUP;
              cnt_q      <= 16'd0;
              lcd_rs_q   <= head[24];
              lcd_data_q <= head[23:0];
            end
          end
          SETUP: begin
            if (phase_done) begin
              state_q  <= WRL;
              cnt_q    <= 16'd0;
              lcd_wr_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          WRL: begin
            if (phase_done) begin
              state_q  <= WRH;
              cnt_q    <= 16'd0;
              lcd_wr_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          WRH: begin
            if (phase_done) begin
              cnt_q <= 16'd0;
              if (pop) begin
                state_q    <= SETUP;
                lcd_rs_q   <= head[24];
                lcd_data_q <= head[23:0];
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          default: begin
            state_q <= RST_HOLD;
            cnt_q   <= 16'd0;
          end
        endcase
      end
    end
  end

  assign lcd_blk_o   = lcd_blk_q;
  assign lcd_rs_o    = lcd_rs_q;
  assign lcd_wr_o    = lcd_wr_q;
  assign lcd_rd_o    = 1'b1;
  assign lcd_rst_o   = lcd_rst_q;
  assign lcd_data_o  = lcd_data_q;
  assign init_done_o = init_done_q;
  assign busy_o      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_lcd_seq.sv
// ---------------------------------------------------------------------------
// tb_lcd_seq
// Self-checking bench for lcd_seq. A timeline model (edge numbers, a command
// queue and the start edge of the current write) predicts every output each
// cycle; directed sections pin the model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_lcd_seq;

  localparam int TS = 2;
  localparam int TL = 4;
  localparam int TH = 4;
  localparam int TR = 16;
  localparam int TW = 32;
  localparam int P  = TS + TL + TH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_rs = 1'b0;
  logic [23:0] cmd_data = 24'd0;
  logic        blk_en = 1'b0;
  logic        soft_rst = 1'b0;

  logic        cmd_ready, lcd_blk, lcd_rs, lcd_wr, lcd_rd, lcd_rst, busy, init_done;
  logic [23:0] lcd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_seq #(
    .T_SETUP(TS), .T_WRL(TL), .T_WRH(TH), .T_RST(TR), .T_RWAIT(TW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_rs_i(cmd_rs), .cmd_data_i(cmd_data),
    .blk_en_i(blk_en), .soft_rst_i(soft_rst),
    .lcd_blk_o(lcd_blk), .lcd_rs_o(lcd_rs), .lcd_wr_o(lcd_wr),
    .lcd_rd_o(lcd_rd), .lcd_rst_o(lcd_rst), .lcd_data_o(lcd_data),
    .busy_o(busy), .init_done_o(init_done)
  );

  // Model state: absolute edge count, the edge at which the reset sequence
  // starts counting, queued commands, start edge of the active write (-1 if
  // none) and the last word put on the bus.
  int          edgeCnt = 0;
  int          relEdge = 1;
  int          curStart = -1;
  int          pushCnt = 0;
  logic [24:0] mq[$];
  logic        expRs = 1'b0;
  logic [23:0] expData = 24'd0;
  logic        expBlk = 1'b0;

  // Model update: reset clears everything; otherwise at each edge the
  // engine pops when free (after init, or when a write's period has elapsed)
  // and an accepted command is appended.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        curStart = -1;
        relEdge  = edgeCnt + 1;
        expRs    = 1'b0;
        expData  = 24'd0;
        expBlk   = 1'b0;
      end else begin
        automatic int  e = edgeCnt + 1;
        automatic bit  doPush;
        automatic bit  free;
        edgeCnt = e;
        expBlk  = blk_en;
        doPush  = cmd_valid && !soft_rst && (mq.size() < 4);
        if (soft_rst) begin
          mq.delete();
          curStart = -1;
          relEdge  = e + 1;
        end else begin
          free = (curStart < 0) ? (e > relEdge + TR + TW) : (e == curStart + P);
          if (free) begin
            if (mq.size() > 0) begin
              {expRs, expData} = mq.pop_front();
              curStart = e;
            end else begin
              curStart = -1;
            end
          end
          if (doPush) begin
            mq.push_back({cmd_rs, cmd_data});
            pushCnt++;
          end
        end
      end
    end
  end

  function automatic bit modelWrLow();
    return (curStart >= 0) && (edgeCnt >= curStart + TS) && (edgeCnt < curStart + TS + TL);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic checkOutput();
    int  e;
    bit  expInit;
    e       = edgeCnt;
    expInit = (e >= relEdge + TR + TW);
    checkVal("lcd_rst", 32'(lcd_rst), 32'(e >= relEdge + TR));
    checkVal("init_done", 32'(init_done), 32'(expInit));
    checkVal("lcd_wr", 32'(lcd_wr), 32'(!modelWrLow()));
    checkVal("busy", 32'(busy), 32'(!expInit || curStart >= 0 || mq.size() != 0));
    checkVal("cmd_ready", 32'(cmd_ready), 32'(mq.size() < 4 && !soft_rst));
    checkVal("lcd_rs", 32'(lcd_rs), 32'(expRs));
    checkVal("lcd_data", 32'(lcd_data), 32'(expData));
    checkVal("lcd_blk", 32'(lcd_blk), 32'(expBlk));
    checkVal("lcd_rd", 32'(lcd_rd), 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput();
    end
  end

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Drive one command for one cycle (bench waits for acceptance up to a bound).
  task automatic applyStimulus(input logic rs, input logic [23:0] data);
    int base;
    base      = pushCnt;
    cmd_valid = 1'b1;
    cmd_rs    = rs;
    cmd_data  = data;
    for (int i = 0; i < 200 && pushCnt == base; i++) nextCycle();
    cmd_valid = 1'b0;
    checkVal("push_accepted", 32'(pushCnt - base), 32'd1);
  endtask

  initial begin
    int   falls[$];
    bit   prevWr;
    bit   sawFull;
    int   base;
    int   lowBeforeInit;

    // Reset values while rst is held (blk_en high must not leak through).
    blk_en = 1'b1;
    repeat (3) nextCycle();
    checkVal("rst_wr", 32'(lcd_wr), 32'd1);
    checkVal("rst_lcdrst", 32'(lcd_rst), 32'd0);
    checkVal("rst_data", 32'(lcd_data), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd1);
    checkVal("rst_ready", 32'(cmd_ready), 32'd1);
    checkVal("rst_blk", 32'(lcd_blk), 32'd0);
    blk_en = 1'b0;
    rst    = 1'b0;

    // Power-up sequence timing, spec edge c = c-th edge after release.
    for (int c = 0; c <= 50; c++) begin
      nextCycle();
      if (c == 15) checkVal("pu_rst_low15", 32'(lcd_rst), 32'd0);
      if (c == 16) checkVal("pu_rst_high16", 32'(lcd_rst), 32'd1);
      if (c == 47) checkVal("pu_init47", 32'(init_done), 32'd0);
      if (c == 48) checkVal("pu_init48", 32'(init_done), 32'd1);
      if (c == 49) checkVal("pu_busy49", 32'(busy), 32'd0);
    end

    // Single write latency.
    cmd_valid = 1'b1;
    cmd_rs    = 1'b1;
    cmd_data  = 24'hA5A5A5;
    nextCycle();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      nextCycle();
      if (k == 1) begin
        checkVal("one_data", 32'(lcd_data), 32'hA5A5A5);
        checkVal("one_rs", 32'(lcd_rs), 32'd1);
      end
      checkVal("one_wr", 32'(lcd_wr), (k >= 3 && k <= 6) ? 32'd0 : 32'd1);
      if (k == 10) checkVal("one_busy10", 32'(busy), 32'd1);
      if (k == 11) checkVal("one_busy11", 32'(busy), 32'd0);
    end

    // Six back-to-back commands: FIFO fills, falls spaced by the write period.
    base    = pushCnt;
    sawFull = 1'b0;
    prevWr  = lcd_wr;
    cmd_valid = 1'b1;
    cmd_rs    = 1'b0;
    cmd_data  = 24'h100000;
    for (int c = 0; c < 90; c++) begin
      nextCycle();
      if (prevWr && !lcd_wr) falls.push_back(c);
      prevWr = lcd_wr;
      if (!cmd_ready) sawFull = 1'b1;
      if (pushCnt - base >= 6) cmd_valid = 1'b0;
      else cmd_data = 24'h100000 + 24'(pushCnt - base);
    end
    checkVal("burst_falls", 32'(falls.size()), 32'd6);
    for (int i = 1; i < falls.size(); i++)
      checkVal("burst_gap", 32'(falls[i] - falls[i-1]), 32'd10);
    checkVal("burst_full_seen", 32'(sawFull), 32'd1);

    // Commands queued during the reset hold are written after init only.
    soft_rst = 1'b1;
    nextCycle();
    soft_rst = 1'b0;
    applyStimulus(1'b0, 24'h000111);
    applyStimulus(1'b1, 24'h000222);
    lowBeforeInit = 0;
    falls.delete();
    prevWr = lcd_wr;
    for (int c = 0; c < 90; c++) begin
      nextCycle();
      if (!lcd_wr && !init_done) lowBeforeInit++;
      if (prevWr && !lcd_wr) falls.push_back(c);
      prevWr = lcd_wr;
    end
    checkVal("hold_no_early_wr", 32'(lowBeforeInit), 32'd0);
    checkVal("hold_two_writes", 32'(falls.size()), 32'd2);

    // soft_rst during a strobe with three more commands queued.
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_rs    = 1'b0;
      cmd_data  = 24'h0C0000 + 24'(i);
      nextCycle();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && !modelWrLow(); i++) nextCycle();
    checkVal("abort_in_wrl", 32'(lcd_wr), 32'd0);
    soft_rst = 1'b1;
    nextCycle();
    soft_rst = 1'b0;
    checkVal("abort_wr_high", 32'(lcd_wr), 32'd1);
    checkVal("abort_lcdrst", 32'(lcd_rst), 32'd0);
    falls.delete();
    prevWr = lcd_wr;
    for (int c = 0; c < 70; c++) begin
      nextCycle();
      if (prevWr && !lcd_wr) falls.push_back(c);
      prevWr = lcd_wr;
    end
    checkVal("abort_no_writes", 32'(falls.size()), 32'd0);

    // Randomized traffic, backlight toggling and occasional soft resets.
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_rs    = 1'($urandom_range(0, 1));
      cmd_data  = 24'($urandom);
      blk_en    = 1'($urandom_range(0, 1));
      soft_rst  = ($urandom_range(0, 399) == 0);
      nextCycle();
    end
    cmd_valid = 1'b0;
    soft_rst  = 1'b0;

    // Asynchronous reset in the middle of a strobe.
    for (int i = 0; i < 200 && (busy !== 1'b0); i++) nextCycle();
    applyStimulus(1'b1, 24'h5A5A5A);
    for (int i = 0; i < 40 && !modelWrLow(); i++) nextCycle();
    checkVal("async_in_wrl", 32'(lcd_wr), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkVal("async_wr", 32'(lcd_wr), 32'd1);
    checkVal("async_lcdrst", 32'(lcd_rst), 32'd0);
    checkVal("async_data", 32'(lcd_data), 32'd0);
    checkVal("async_rs", 32'(lcd_rs), 32'd0);
    checkVal("async_init", 32'(init_done), 32'd0);
    checkVal("async_busy", 32'(busy), 32'd1);
    checkVal("async_ready", 32'(cmd_ready), 32'd1);
    checkVal("async_blk", 32'(lcd_blk), 32'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 24'h123456);
    repeat (80) nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
